// File: rtl/mem_access_initiator_pkg.sv
// Shared types and constants for the MEM-stage memory access initiator.
// State encodings mirror the IDLE/BUSY/DONE access sequence.
package mem_access_initiator_pkg;

    typedef enum logic [1:0] {
        MAI_IDLE = 2'd0,
        MAI_BUSY = 2'd1,
        MAI_DONE = 2'd2
    } mai_state_e;

    localparam int MAI_TIMEOUT_W = 8;

endpackage

// File: rtl/mem_access_initiator_timeout.sv
// Saturating BUSY-cycle counter; expired flags the last permitted wait cycle.
module mem_timeout_counter
    import mem_access_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [MAI_TIMEOUT_W-1:0] LAST = MAI_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MAI_TIMEOUT_W-1:0] SAT  = '1;

    logic [MAI_TIMEOUT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    cnt_q <= '0;
        else if (clr)                cnt_q <= '0;
        else if (en && cnt_q != SAT) cnt_q <= cnt_q + 1'b1;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_initiator.sv
// MEM-stage initiator: issues one load/store per request, waits for mem_ready
// (or a timeout), then reports completion. Optional MEM_ALIGN_CHECK_EN aborts misaligned requests.
module mem_access_initiator
    import mem_access_initiator_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready
);

    localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'(3);

    mai_state_e        state_q;
    logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
    logic              rd_q, wr_q, err_q;
    logic              req, misalign, expired;

    assign req = req_read | req_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = |req_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != MAI_BUSY),
        .en      (state_q == MAI_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MAI_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                MAI_IDLE: begin
                    err_q <= 1'b0;
                    if (req && misalign) begin
                        state_q <= MAI_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (req) begin
                        state_q <= MAI_BUSY;
                        addr_q  <= req_addr & ~LOW_MASK;
                        wdata_q <= req_wdata;
                        wr_q    <= req_write;
                        rd_q    <= req_read & ~req_write;
                    end
                end
                MAI_BUSY: begin
                    // mem_ready wins over a coincident timeout
                    if (mem_ready) begin
                        if (rd_q) rdata_q <= mem_read_data;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= MAI_DONE;
                    end else if (expired) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= MAI_DONE;
                    end
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= MAI_IDLE;
                end
            endcase
        end
    end

    // Gated by rst so the pipeline unfreezes the instant reset asserts.
    assign stall          = rst & (((state_q == MAI_IDLE) & req) | (state_q == MAI_BUSY));
    assign rsp_valid      = (state_q == MAI_DONE);
    assign err            = err_q;
    assign rsp_rdata      = rdata_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench for mem_access_initiator: directed accesses push expected
// responses; a monitor pops and compares on every rsp_valid.
module tb_mem_access_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall, rsp_valid, err, mem_read, mem_write, mem_ready;
    logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb_q[$];

    int ready_after = 1;
    int scnt = 0;
    int rcyc, wcyc;
    logic [31:0] last_addr, wr_addr, wr_data;

    always #5 clk = ~clk;

    mem_access_initiator #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready)
    );

    // Memory model: ready on the Nth strobe cycle (0 = never)
    always @(posedge clk) scnt <= (mem_read | mem_write) ? scnt + 1 : 0;
    assign mem_ready = (mem_read | mem_write) && ready_after != 0 && scnt == ready_after - 1;
    assign mem_read_data = (mem_addr == 32'h10) ? 32'hDEADBEEF : ~mem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        logic [32:0] e;
        @(negedge clk);
        if (rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[32:1]);
                check("rsp_err", {31'd0, err}, {31'd0, e[0]});
            end
        end
    end

    // Called at posedge+1; returns with the DUT back in IDLE at posedge+1.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int rdy, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_stall, input string nm);
        int  ns, cyc;
        bit  done;
        ready_after = rdy;
        req_read = rd; req_write = wr; req_addr = a; req_wdata = wd;
        sb_q.push_back({exp_d, exp_e});
        ns = 0; cyc = 0; done = 0; rcyc = 0; wcyc = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stall) ns++;
            if (mem_read) rcyc++;
            if (mem_write) wcyc++;
            if (mem_read | mem_write) last_addr = mem_addr;
            if (mem_write && mem_ready) begin
                wr_addr = mem_addr;
                wr_data = mem_write_data;
            end
            if (rsp_valid) done = 1;
            @(posedge clk); #1;
            req_read = 0; req_write = 0;
            cyc = c + 1;
            if (done) break;
        end
        check({nm, "_completed"}, {31'd0, done}, 32'd1);
        check({nm, "_stall_cycles"}, ns, exp_stall);
        check({nm, "_total_cycles"}, cyc, exp_stall + 1);
    endtask

    initial begin
        #1;
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        req_read = 1; #1;
        check("rst_stall_gated", {31'd0, stall}, 0);
        req_read = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        check("idle_no_req_stall", {31'd0, stall}, 0);

        access(1, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0, 2, "t1_read");
        check("t1_rcyc", rcyc, 1);

        access(0, 1, 32'h22, 32'hCAFEF00D, 4, 32'hDEADBEEF, 0, 5, "t2_write");
        check("t2_wcyc", wcyc, 4);
        check("t2_addr", wr_addr, 32'h20);
        check("t2_wdata", wr_data, 32'hCAFEF00D);

        access(1, 0, 32'h40, 0, 0, 32'h0, 1, 17, "t3_timeout");
        check("t3_rcyc", rcyc, 16);
        check("t3_strobes_drop", {30'd0, mem_read, mem_write}, 0);

        access(1, 1, 32'h30, 32'h11223344, 1, 32'h0, 0, 2, "t6_rw");
        check("t6_rcyc", rcyc, 0);
        check("t6_wcyc", wcyc, 1);
        check("t6_wdata", wr_data, 32'h11223344);

        access(1, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0, 2, "t6_ld0");
        access(1, 0, 32'h14, 0, 1, 32'hFFFFFFEB, 0, 2, "t6_ld1");
        check("t6_ld1_addr", last_addr, 32'h14);

`ifdef MEM_ALIGN_CHECK_EN
        access(1, 0, 32'h13, 0, 1, 32'h0, 1, 1, "t5_misalign");
        check("t5_rcyc", rcyc, 0);
`else
        access(1, 0, 32'h13, 0, 1, 32'hDEADBEEF, 0, 2, "t5_misalign");
        check("t5_addr", last_addr, 32'h10);
`endif

        ready_after = 0;
        req_read = 1; req_addr = 32'h50;
        @(posedge clk); #1;
        req_read = 0;
        #1;
        check("t4_busy_read", {31'd0, mem_read}, 1);
        rst = 0;
        #1;
        check("t4_rst_strobes", {30'd0, mem_read, mem_write}, 0);
        check("t4_rst_stall", {31'd0, stall}, 0);
        check("t4_rst_valid", {31'd0, rsp_valid}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        repeat (5) @(posedge clk);
        #1;
        check("t4_after_stall", {31'd0, stall}, 0);
        check("t4_after_strobes", {30'd0, mem_read, mem_write}, 0);

        @(posedge clk); #1;
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
